fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Output reorder stage for the R2SDF FFT pipeline. It accepts one frame of N samples per transform in bit-reversed order and emits the same frame in natural order.
- Storage is an internal two-bank ping-pong buffer of 2*N words, built as a simple dual-port block RAM (one write port, one registered read port).
- The writer side fills one bank while the reader side drains the other, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, sample width in bits (packed {re,im}).
- N, 16, FFT length; must be a power of two, N >= 4.
- LOG2N, $clog2(N), index width; derived, do not override.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample (in_ready = ~full[w_sel]).
- in_data  input  WIDTH  input sample, bit-reversed order.
- out_valid  output  1  out_data holds a valid sample.
- out_ready  input  1  downstream accepts the sample.
- out_data  output  WIDTH  output sample, natural order.
- out_last  output  1  high with the sample at natural index N-1.

Behaviour:
- Storage: 2*N x WIDTH RAM with a block RAM style attribute. Address is {bank, idx}.
  - Write: synchronous.
  - Read: synchronous, 1-cycle latency; the read data register updates only on a read enable.
- Write FSM:
  - State: w_sel (bank), wcnt (LOG2N bits), full[1:0].
  - Accept a sample when in_valid && in_ready. The sample is written to {w_sel, bitrev(wcnt)} and wcnt increments.
  - When wcnt == N-1 is accepted: full[w_sel] <= 1, w_sel toggles, wcnt wraps to 0.
- Read FSM:
  - State: r_sel, rcnt (LOG2N bits).
  - rd_en = full[r_sel] && (~out_valid || out_ready). rd_en reads {r_sel, rcnt}; rcnt increments.
  - When rd_en fires with rcnt == N-1: full[r_sel] <= 0 on that edge, r_sel toggles, rcnt wraps to 0.
- Output register:
  - out_data is the RAM read data register.
  - On rd_en: out_valid <= 1 and out_last <= (rcnt == N-1).
  - Otherwise, if out_ready: out_valid <= 0 and out_last <= 0.
  - During a stall, out_data and out_last hold.
- Latency: the last sample of a frame is accepted in cycle c. Then:
  - full is set at the end of cycle c.
  - rd_en is asserted in cycle c+1.
  - The first out_valid appears in cycle c+2.
- Throughput: 1 sample/cycle sustained on both sides when out_ready = 1.
- Boundary conditions:
  - Both banks full: in_ready = 0. The writer stalls, keeping wcnt and w_sel.
  - Both banks empty: rd_en = 0. out_valid falls after the current sample is accepted.
  - The same bank's full flag being set and cleared in one cycle is impossible: the writer only sets full[w_sel] and the reader only clears full[r_sel], and w_sel/r_sel point at different banks whenever both events can coincide. Simultaneous set of one bank and clear of the other are both honoured.
  - A bank becomes writable on the edge that issues its last read. An overwrite in the next cycle is safe because the data is already in the read data register.
  - in_valid while in_ready = 0: ignored and not written. in_data is a don't-care when in_valid = 0.
  - out_ready is a don't-care while out_valid = 0.
- Reset (asynchronous assert, any time, including mid-frame):
  - out_valid = 0, out_last = 0, in_ready = 1.
  - full = 0, w_sel = r_sel = 0, wcnt = rcnt = 0.
  - Partial frames are discarded.
  - RAM contents and out_data are not reset; out_data is a don't-care while out_valid = 0.
- Release of rstn must be synchronous to clk (handled upstream).

Test Plan:
- Single frame, N=16, in_data = index 0..15 on consecutive cycles, out_ready = 1 -> outputs 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. The first out_valid comes 2 cycles after the last input, and out_last is high only with 15.
- Continuous streaming, 4 back-to-back frames (frame f sample k = 16f+k), out_ready = 1 -> in_ready stays 1 throughout, output is gap-free, and each frame is correctly reordered with no bank mixing.
- Backpressure, out_ready = 0 for 40 cycles while 3 frames are offered -> the 2 banks fill and in_ready drops to 0 at the third frame's first sample. out_data and out_last hold stable. After release, all frames are emitted in order with no loss or duplication.
- Random in_valid (50%) and random out_ready (30%) over 100 frames -> scoreboard matches the bit-reverse permutation exactly, and every handshake obeys the hold rules.
- Reset asserted mid-frame (after 7 inputs, with 5 outputs of the previous frame pending) -> out_valid = 0 and in_ready = 1 immediately (asynchronous). A fresh frame then reorders correctly with no stale samples.
- N=8 instance with inputs 0..7 -> outputs 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Output reorder stage for the R2SDF FFT: takes frames in bit-reversed order and
// emits them in natural order through a two-bank ping-pong RAM.
`timescale 1ns/1ps
module fft_bitrev_reorder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 16,
    parameter int unsigned LOG2N = $clog2(N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam int unsigned     AW       = LOG2N + 1;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = v[int'(LOG2N) - 1 - i];
        end
        return r;
    endfunction

    (* ram_style = "block" *) logic [WIDTH-1:0] mem [2*N];

    logic             w_sel;
    logic             r_sel;
    logic [LOG2N-1:0] wcnt;
    logic [LOG2N-1:0] rcnt;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wr_en;
    logic             rd_en;
    logic             wr_last;
    logic             rd_last;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;

    assign in_ready = ~full[w_sel];
    assign wr_en    = in_valid & in_ready;
    assign rd_en    = full[r_sel] & (~out_valid | out_ready);
    assign wr_last  = (wcnt == LAST_IDX);
    assign rd_last  = (rcnt == LAST_IDX);
    assign wr_addr  = {w_sel, bitrev(wcnt)};
    assign rd_addr  = {r_sel, rcnt};

    // Writer sets only full[w_sel], reader clears only full[r_sel]; both may fire together.
    always_comb begin
        full_nxt = full;
        if (wr_en && wr_last) begin
            full_nxt[w_sel] = 1'b1;
        end
        if (rd_en && rd_last) begin
            full_nxt[r_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    // Read data register doubles as the output data register; it holds during stalls.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            out_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_sel <= 1'b0;
            wcnt  <= '0;
            full  <= '0;
        end else begin
            full <= full_nxt;
            if (wr_en) begin
                wcnt <= wcnt + LOG2N'(1);
                if (wr_last) begin
                    w_sel <= ~w_sel;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sel     <= 1'b0;
            rcnt      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (rd_en) begin
                rcnt      <= rcnt + LOG2N'(1);
                out_valid <= 1'b1;
                out_last  <= rd_last;
                if (rd_last) begin
                    r_sel <= ~r_sel;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed and randomized checks of the bit-reverse reorder buffer (N=16 and N=8).
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;

    logic        clk;
    logic        rstn;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] in_data, out_data;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_last8;
    logic [31:0] in_data8, out_data8;

    int n_checks;
    int n_pass;
    int first_low_sent;
    int ready_low_cnt;
    int gap_cnt;
    int sent_at_release;

    fft_bitrev_reorder #(.WIDTH(32), .N(16)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    fft_bitrev_reorder #(.WIDTH(32), .N(8)) dut8 (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_last(out_last8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int tb_bitrev(input int v, input int lg);
        int r;
        r = 0;
        for (int i = 0; i < lg; i++) begin
            r = (r << 1) | ((v >> i) & 1);
        end
        return r;
    endfunction

    // Streams frames of base+index into the N=16 instance and scoreboards the output.
    task automatic stream_frames(input int nframes, input int vpct, input int rpct,
                                 input int stall, input logic [31:0] base);
        logic [31:0] fb [16];
        logic [31:0] exp_q [$];
        logic [31:0] prev_data, e;
        logic        prev_stall, prev_last, exp_last;
        int          sent, got, cyc, total;
        bit          seen_out;
        total = nframes * 16;
        sent = 0; got = 0; cyc = 0; seen_out = 0;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        first_low_sent = -1; ready_low_cnt = 0; gap_cnt = 0; sent_at_release = -1;
        while (got < total && cyc < 20000) begin
            @(posedge clk); #1;
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last)
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                else n_pass++;
            end
            if (cyc == stall) sent_at_release = sent;
            in_valid  = (sent < total) && (int'($urandom_range(99)) < vpct);
            in_data   = base + 32'(sent);
            out_ready = (cyc >= stall) && (int'($urandom_range(99)) < rpct);
            if (sent < total && in_ready !== 1'b1) begin
                ready_low_cnt++;
                if (first_low_sent < 0) first_low_sent = sent;
            end
            if (seen_out && out_valid !== 1'b1) gap_cnt++;
            if (in_valid && in_ready) begin
                fb[sent % 16] = in_data;
                sent++;
                if (sent % 16 == 0) begin
                    for (int j = 0; j < 16; j++) exp_q.push_back(fb[tb_bitrev(j, 4)]);
                end
            end
            if (out_valid && out_ready) begin
                seen_out = 1;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: got data=%h, want no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    exp_last = (got % 16 == 15);
                    if (out_data !== e || out_last !== exp_last)
                        $display("FAIL stream_data[%0d]: got data=%h last=%b, want data=%h last=%b",
                                 got, out_data, out_last, e, exp_last);
                    else n_pass++;
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (got != total) $display("FAIL stream_count: got %0d outputs, want %0d", got, total);
        else n_pass++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset16: valid=%b last=%b in_ready=%b, want 0 0 1", out_valid, out_last, in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid8 !== 1'b0 || out_last8 !== 1'b0 || in_ready8 !== 1'b1)
            $display("FAIL reset8: valid=%b last=%b in_ready=%b, want 0 0 1", out_valid8, out_last8, in_ready8);
        else n_pass++;
        rstn = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_release: valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        int exp16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        int not_ready;
        not_ready = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = 32'(k); out_ready = 1'b1;
            if (in_ready !== 1'b1) not_ready++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (not_ready != 0) $display("FAIL single_in_ready: low in %0d cycles, want 0", not_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL single_latency_c1: valid=%b, want 0", out_valid);
        else n_pass++;
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(exp16[k]) || out_last !== (k == 15))
                $display("FAIL single_out[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b",
                         k, out_valid, out_data, out_last, exp16[k], (k == 15));
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL single_drain: valid=%b, want 0", out_valid);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_n8();
        int exp8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        while (got < 8 && cyc < 100) begin
            @(posedge clk); #1;
            in_valid8 = (sent < 8); in_data8 = 32'(sent); out_ready8 = 1'b1;
            if (in_valid8 && in_ready8) sent++;
            if (out_valid8 && out_ready8) begin
                n_checks++;
                if (out_data8 !== 32'(exp8[got]) || out_last8 !== (got == 7))
                    $display("FAIL n8_out[%0d]: data=%0d last=%b, want %0d %b",
                             got, out_data8, out_last8, exp8[got], (got == 7));
                else n_pass++;
                got++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        n_checks++;
        if (got != 8) $display("FAIL n8_count: got %0d, want 8", got);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        stream_frames(4, 100, 100, 0, 32'h0);
        n_checks++;
        if (ready_low_cnt != 0) $display("FAIL b2b_in_ready: low %0d cycles, want 0", ready_low_cnt);
        else n_pass++;
        n_checks++;
        if (gap_cnt != 0) $display("FAIL b2b_gaps: %0d gap cycles, want 0", gap_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        stream_frames(3, 100, 100, 40, 32'h1000);
        n_checks++;
        if (first_low_sent != 32) $display("FAIL bp_ready_drop: at sample %0d, want 32", first_low_sent);
        else n_pass++;
        n_checks++;
        if (sent_at_release != 32) $display("FAIL bp_accepted: %0d before release, want 32", sent_at_release);
        else n_pass++;
    endtask

    task automatic test_random();
        stream_frames(100, 50, 30, 0, 32'h5000_0000);
    endtask

    task automatic test_reset_mid_frame();
        int sent, got, cyc;
        logic [31:0] e;
        sent = 0; got = 0; cyc = 0;
        while (got < 11 && cyc < 200) begin
            @(posedge clk); #1;
            in_valid = (sent < 23); in_data = 32'h200 + 32'(sent); out_ready = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                e = 32'h200 + 32'(tb_bitrev(got, 4));
                n_checks++;
                if (out_data !== e) $display("FAIL mid_prev[%0d]: data=%h, want %h", got, out_data, e);
                else n_pass++;
                got++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (sent != 23 || out_valid !== 1'b1)
            $display("FAIL mid_setup: sent=%0d valid=%b, want 23 1", sent, out_valid);
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mid_async_reset: valid=%b last=%b in_ready=%b, want 0 0 1",
                     out_valid, out_last, in_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        stream_frames(1, 100, 100, 0, 32'h300);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rstn = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
        test_reset();
        test_single_frame();
        test_n8();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
